// File: rtl/ex_operand_ctrl_pkg.sv
// Shared types for the execute-stage operand/flag controller.
// Select encodings, FSM states and the scoreboard entry layout.
package ex_ctrl_pkg;

    localparam int SB_RA_W      = 3;
    localparam int POP_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        S1_WB  = 2'b00,
        S1_MEM = 2'b01,
        S1_RF  = 2'b10
    } src1_sel_t;

    typedef enum logic [1:0] {
        S2_RF    = 2'b00,
        S2_WB    = 2'b01,
        S2_MEM   = 2'b10,
        S2_SHAMT = 2'b11
    } src2_sel_t;

    typedef enum logic [1:0] {
        C_ALU = 2'b00,
        C_SET = 2'b01,
        C_CLR = 2'b10
    } carry_sel_t;

    typedef enum logic [1:0] {
        FL_RUN     = 2'b00,
        FL_WAIT    = 2'b01,
        FL_RESTORE = 2'b10
    } fl_state_t;

    typedef struct packed {
        logic               valid;
        logic [SB_RA_W-1:0] rd;
        logic               wr_en;
        logic               is_load;
    } sb_entry_t;

    // A used source hits an entry that will write the same register.
    function automatic logic sb_hit(
        input sb_entry_t          e,
        input logic [SB_RA_W-1:0] rs,
        input logic               use_rs
    );
        return use_rs && e.valid && e.wr_en && (e.rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_ctrl_if.sv
// Decode/execute control bundle for ex_operand_ctrl.
// master = decode side, slave = controller.
interface ex_operand_ctrl_if #(
    parameter int RA_W = 3
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_use_shamt;
    logic [RA_W-1:0] id_rd;
    logic            id_wr_en;
    logic            id_is_load;
    logic [1:0]      id_carry_op;
    logic            id_flag_wr;
    logic            id_rti;
    logic            mem_pop_valid;
    logic            stall_id;
    logic [1:0]      alu_src1_select;
    logic [1:0]      alu_src2_select;
    logic [1:0]      carry_sel;
    logic            flag_regsel;
    logic            flagreg_enable;
    logic            flags_pop_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_use_shamt, id_rd, id_wr_en, id_is_load,
        output id_carry_op, id_flag_wr, id_rti, mem_pop_valid,
        input  stall_id, alu_src1_select, alu_src2_select,
        input  carry_sel, flag_regsel, flagreg_enable, flags_pop_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_use_shamt, id_rd, id_wr_en, id_is_load,
        input  id_carry_op, id_flag_wr, id_rti, mem_pop_valid,
        output stall_id, alu_src1_select, alu_src2_select,
        output carry_sel, flag_regsel, flagreg_enable, flags_pop_err
    );

endinterface

// File: rtl/ex_operand_ctrl_scoreboard.sv
// EX/MEM in-flight destination tracker with per-source match logic.
// WB is not tracked: the register file is write-before-read.
module ex_scoreboard
    import ex_ctrl_pkg::*;
#(
    parameter int RA_W = SB_RA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_issue,
    input  logic [RA_W-1:0] i_rd,
    input  logic            i_wr_en,
    input  logic            i_is_load,
    input  logic [RA_W-1:0] i_rs1,
    input  logic [RA_W-1:0] i_rs2,
    input  logic            i_use1,
    input  logic            i_use2,
    output logic            o_hit_ex1,
    output logic            o_hit_mem1,
    output logic            o_hit_ex2,
    output logic            o_hit_mem2,
    output logic            o_ld_hit1,
    output logic            o_ld_hit2
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;

    // Shift decode fields into EX each cycle; idle or stalled slots become bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_ex  <= i_issue ? '{valid: 1'b1, rd: i_rd, wr_en: i_wr_en,
                                is_load: i_is_load} : '0;
            r_mem <= r_ex;
        end
    end

    // Match both sources against EX and MEM; a load in EX is a load-use hit.
    always_comb begin
        o_hit_ex1  = sb_hit(r_ex, i_rs1, i_use1);
        o_hit_mem1 = sb_hit(r_mem, i_rs1, i_use1);
        o_hit_ex2  = sb_hit(r_ex, i_rs2, i_use2);
        o_hit_mem2 = sb_hit(r_mem, i_rs2, i_use2);
        o_ld_hit1  = o_hit_ex1 && r_ex.is_load;
        o_ld_hit2  = o_hit_ex2 && r_ex.is_load;
    end

endmodule

// File: rtl/ex_operand_ctrl.sv
// Execute-stage operand/flag controller: forwarding selects,
// load-use stall and the RTI flag-restore sequencer.
module ex_operand_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int RA_W     = SB_RA_W,
    parameter int POP_WAIT = POP_WAIT_DEF
) (
    input logic               clk,
    input logic               rst_n,
    ex_operand_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(POP_WAIT) + 1;

    fl_state_t        r_state;
    fl_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    src1_sel_t        r_src1;
    src2_sel_t        r_src2;
    logic [1:0]       r_carry;
    logic             r_flag_en;
    logic             r_pop_err;

    logic w_use2;
    logic w_hit_ex1;
    logic w_hit_mem1;
    logic w_hit_ex2;
    logic w_hit_mem2;
    logic w_ld_hit1;
    logic w_ld_hit2;
    logic w_ld_stall;
    logic w_stall;
    logic w_issue;
    logic w_timeout;
    logic w_fsm_stall;
    logic w_restore;
    logic w_err_set;

    // A shift amount replaces rs2, so rs2 cannot create a hazard.
    assign w_use2 = bus.id_use_rs2 && !bus.id_use_shamt;

    ex_scoreboard #(
        .RA_W (RA_W)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issue    (w_issue),
        .i_rd       (bus.id_rd),
        .i_wr_en    (bus.id_wr_en),
        .i_is_load  (bus.id_is_load),
        .i_rs1      (bus.id_rs1),
        .i_rs2      (bus.id_rs2),
        .i_use1     (bus.id_use_rs1),
        .i_use2     (w_use2),
        .o_hit_ex1  (w_hit_ex1),
        .o_hit_mem1 (w_hit_mem1),
        .o_hit_ex2  (w_hit_ex2),
        .o_hit_mem2 (w_hit_mem2),
        .o_ld_hit1  (w_ld_hit1),
        .o_ld_hit2  (w_ld_hit2)
    );

    assign w_ld_stall   = bus.id_valid && (w_ld_hit1 || w_ld_hit2);
    assign w_stall      = rst_n && (w_ld_stall || w_fsm_stall);
    assign w_issue      = bus.id_valid && !w_stall;
    assign w_timeout    = (r_wait_cnt == CNT_W'(POP_WAIT - 1));
    assign bus.stall_id = w_stall;

    // Flag sequencer state and the WAIT cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FL_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= (r_state == FL_WAIT) ? r_wait_cnt + 1'b1 : '0;
        end
    end

    // Enter WAIT only when the RTI actually issues; a pop beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FL_RUN: begin
                if (w_issue && bus.id_rti) w_state_nxt = FL_WAIT;
            end
            FL_WAIT: begin
                if (bus.mem_pop_valid) w_state_nxt = FL_RESTORE;
                else if (w_timeout)    w_state_nxt = FL_RUN;
            end
            FL_RESTORE: begin
                w_state_nxt = (w_issue && bus.id_rti) ? FL_WAIT : FL_RUN;
            end
            default: w_state_nxt = FL_RUN;
        endcase
    end

    // Sequencer outputs: decode stall in WAIT, flag load in RESTORE.
    always_comb begin
        w_fsm_stall = 1'b0;
        w_restore   = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            FL_WAIT: begin
                w_fsm_stall = 1'b1;
                w_err_set   = !bus.mem_pop_valid && w_timeout;
            end
            FL_RESTORE: w_restore = 1'b1;
            default:    ;
        endcase
    end

    // EX-aligned selects; the EX producer is newer than MEM so it wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src1    <= S1_RF;
            r_src2    <= S2_RF;
            r_carry   <= C_ALU;
            r_flag_en <= 1'b0;
            r_pop_err <= 1'b0;
        end else begin
            if (w_err_set) r_pop_err <= 1'b1;
            if (w_issue) begin
                r_src1    <= w_hit_ex1  ? S1_MEM :
                             w_hit_mem1 ? S1_WB  : S1_RF;
                r_src2    <= bus.id_use_shamt ? S2_SHAMT :
                             w_hit_ex2        ? S2_MEM   :
                             w_hit_mem2       ? S2_WB    : S2_RF;
                r_carry   <= bus.id_carry_op;
                r_flag_en <= bus.id_flag_wr;
            end else begin
                r_src1    <= S1_RF;
                r_src2    <= S2_RF;
                r_carry   <= C_ALU;
                r_flag_en <= 1'b0;
            end
        end
    end

    assign bus.alu_src1_select = r_src1;
    assign bus.alu_src2_select = r_src2;
    assign bus.carry_sel       = r_carry;
    assign bus.flag_regsel     = w_restore;
    assign bus.flagreg_enable  = r_flag_en || w_restore;
    assign bus.flags_pop_err   = r_pop_err;

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// Bench for ex_operand_ctrl: directed scenarios plus random traffic
// against a history-based reference model.
module tb_ex_operand_ctrl;

    localparam int PW = 4;

    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic       u1;
        logic       u2;
        logic       sh;
        logic       wr;
        logic       ld;
        logic [1:0] cop;
        logic       fw;
        logic       rti;
    } ins_t;

    typedef struct {
        int         cyc;
        logic [2:0] rd;
        logic       wr;
        logic       ld;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ex_operand_ctrl_if #(.RA_W(3)) bus();

    ex_operand_ctrl #(
        .RA_W     (3),
        .POP_WAIT (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t hist[$];
    int   now    = 0;
    int   mode   = 0;
    int   waited = 0;
    logic m_err  = 1'b0;
    int   e_s1, e_s2, e_cy, e_fen, e_fsel;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // Age in cycles of the youngest in-flight writer of rs (1 or 2), else 0.
    function automatic int age_of(input logic [2:0] rs, input logic use_rs);
        if (!use_rs) return 0;
        foreach (hist[i])
            if (hist[i].wr && hist[i].rd == rs && now - hist[i].cyc <= 2)
                return now - hist[i].cyc;
        return 0;
    endfunction

    function automatic logic ld_pending(input logic [2:0] rs, input logic use_rs);
        if (!use_rs) return 1'b0;
        foreach (hist[i])
            if (now - hist[i].cyc == 1 && hist[i].wr && hist[i].ld && hist[i].rd == rs)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic ins_t nop();
        ins_t x = '{default: 0};
        return x;
    endfunction

    function automatic ins_t alu(input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
        ins_t x = nop();
        x.v = 1; x.rd = rd; x.wr = 1; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1;
        return x;
    endfunction

    function automatic ins_t ldd(input logic [2:0] rd);
        ins_t x = nop();
        x.v = 1; x.rd = rd; x.wr = 1; x.ld = 1; x.u1 = 1; x.rs1 = 3'd0;
        return x;
    endfunction

    function automatic ins_t rnd();
        ins_t x;
        x.v   = ($urandom_range(9) != 0);
        x.rs1 = 3'($urandom_range(3));
        x.rs2 = 3'($urandom_range(3));
        x.rd  = 3'($urandom_range(3));
        x.u1  = 1'($urandom_range(1));
        x.u2  = 1'($urandom_range(1));
        x.sh  = ($urandom_range(4) == 0);
        x.wr  = ($urandom_range(3) != 0);
        x.ld  = ($urandom_range(2) == 0);
        x.cop = 2'($urandom_range(2));
        x.fw  = 1'($urandom_range(1));
        x.rti = ($urandom_range(19) == 0);
        return x;
    endfunction

    // One cycle: drive at negedge, check the stall, advance model, check EX outputs.
    task automatic step(input ins_t x, input logic pop);
        logic stall_e;
        logic iss;
        int   a1;
        int   a2;
        @(negedge clk);
        bus.id_valid      = x.v;
        bus.id_rs1        = x.rs1;
        bus.id_rs2        = x.rs2;
        bus.id_use_rs1    = x.u1;
        bus.id_use_rs2    = x.u2;
        bus.id_use_shamt  = x.sh;
        bus.id_rd         = x.rd;
        bus.id_wr_en      = x.wr;
        bus.id_is_load    = x.ld;
        bus.id_carry_op   = x.cop;
        bus.id_flag_wr    = x.fw;
        bus.id_rti        = x.rti;
        bus.mem_pop_valid = pop;
        #1;
        stall_e = rst_n && ((x.v && (ld_pending(x.rs1, x.u1) ||
                  ld_pending(x.rs2, x.u2 && !x.sh))) || mode == 1);
        chk("stall_id", int'(bus.stall_id), int'(stall_e));
        iss = x.v && !stall_e;
        a1  = age_of(x.rs1, x.u1);
        a2  = age_of(x.rs2, x.u2 && !x.sh);
        if (!rst_n) begin
            hist.delete();
            mode = 0; waited = 0; m_err = 1'b0;
            e_s1 = 2; e_s2 = 0; e_cy = 0; e_fen = 0; e_fsel = 0;
        end else begin
            case (mode)
                0: if (iss && x.rti) begin mode = 1; waited = 0; end
                1: begin
                    waited++;
                    if (pop) mode = 2;
                    else if (waited == PW) begin mode = 0; m_err = 1'b1; end
                end
                default: begin
                    mode = (iss && x.rti) ? 1 : 0;
                    waited = 0;
                end
            endcase
            if (iss) begin
                e_s1  = (a1 == 1) ? 1 : (a1 == 2) ? 0 : 2;
                e_s2  = x.sh ? 3 : (a2 == 1) ? 2 : (a2 == 2) ? 1 : 0;
                e_cy  = int'(x.cop);
                e_fen = int'(x.fw);
                hist.push_front('{now, x.rd, x.wr, x.ld});
                if (hist.size() > 4) void'(hist.pop_back());
            end else begin
                e_s1 = 2; e_s2 = 0; e_cy = 0; e_fen = 0;
            end
            e_fsel = (mode == 2) ? 1 : 0;
            if (e_fsel == 1) e_fen = 1;
        end
        now++;
        @(posedge clk);
        #1;
        chk("src1", int'(bus.alu_src1_select), e_s1);
        chk("src2", int'(bus.alu_src2_select), e_s2);
        chk("carry_sel", int'(bus.carry_sel), e_cy);
        chk("flagreg_enable", int'(bus.flagreg_enable), e_fen);
        chk("flag_regsel", int'(bus.flag_regsel), e_fsel);
        chk("flags_pop_err", int'(bus.flags_pop_err), int'(m_err));
    endtask

    initial begin
        ins_t x;

        rst_n = 1'b0;
        x = alu(3'd1, 3'd1, 3'd1);
        x.fw = 1; x.cop = 2'd1;
        repeat (3) step(x, 1'b0);
        chk("rst_src1", int'(bus.alu_src1_select), 2);
        chk("rst_fen", int'(bus.flagreg_enable), 0);
        rst_n = 1'b1;
        step(alu(3'd2, 3'd1, 3'd1), 1'b0);
        chk("rst_nofill", int'(bus.alu_src1_select), 2);

        step(alu(3'd1, 3'd5, 3'd6), 1'b0);
        step(alu(3'd2, 3'd1, 3'd3), 1'b0);
        chk("fwd_mem", int'(bus.alu_src1_select), 1);
        step(alu(3'd1, 3'd5, 3'd6), 1'b0);
        step(nop(), 1'b0);
        step(alu(3'd2, 3'd1, 3'd3), 1'b0);
        chk("fwd_wb", int'(bus.alu_src1_select), 0);

        step(ldd(3'd4), 1'b0);
        x = alu(3'd5, 3'd4, 3'd4);
        step(x, 1'b0);
        chk("lu_bubble", int'(bus.alu_src1_select), 2);
        step(x, 1'b0);
        chk("lu_src1", int'(bus.alu_src1_select), 0);
        chk("lu_src2", int'(bus.alu_src2_select), 1);

        step(alu(3'd2, 3'd0, 3'd0), 1'b0);
        step(ldd(3'd6), 1'b0);
        x = alu(3'd2, 3'd2, 3'd6);
        x.sh = 1;
        step(x, 1'b0);
        chk("shamt_src2", int'(bus.alu_src2_select), 3);
        chk("shamt_src1", int'(bus.alu_src1_select), 0);

        x = nop(); x.v = 1; x.fw = 1;
        x.cop = 2'd1; step(x, 1'b0);
        chk("setc", int'(bus.carry_sel), 1);
        x.cop = 2'd2; step(x, 1'b0);
        chk("clrc", int'(bus.carry_sel), 2);
        step(alu(3'd7, 3'd7, 3'd7), 1'b0);
        chk("add_carry", int'(bus.carry_sel), 0);

        x = nop(); x.v = 1; x.rti = 1;
        step(x, 1'b0);
        step(nop(), 1'b0);
        step(nop(), 1'b1);
        chk("rti_regsel", int'(bus.flag_regsel), 1);
        step(nop(), 1'b0);
        chk("rti_done", int'(bus.flag_regsel), 0);
        chk("rti_noerr", int'(bus.flags_pop_err), 0);

        step(x, 1'b0);
        repeat (PW) step(nop(), 1'b0);
        chk("pop_timeout", int'(bus.flags_pop_err), 1);

        step(x, 1'b0);
        step(nop(), 1'b0);
        rst_n = 1'b0;
        step(nop(), 1'b0);
        rst_n = 1'b1;
        step(alu(3'd1, 3'd2, 3'd3), 1'b0);
        chk("rst_abort_err", int'(bus.flags_pop_err), 0);

        repeat (600) begin
            rst_n = ($urandom_range(99) != 0);
            step(rnd(), ($urandom_range(2) == 0));
        end
        rst_n = 1'b1;
        repeat (4) step(nop(), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
